// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Single-port main-memory arbiter for the cpu. Three requesters share the
// external memory: Dcache write-back, Dcache line read and Icache line read.
// One transfer at a time is granted by fixed priority. The transfer runs to
// completion on the mem_enable / mem_ack handshake. The winner then gets a
// one-cycle ack, plus the line data for reads.
//
// Ports
//   clk            : rising-edge clock
//   reset          : asynchronous, active-low, clears all state
//   ic_read_*      : Icache line-read request/address in, ack/data out
//   dc_read_*      : Dcache line-read request/address in, ack/data out
//   dc_write_*     : Dcache write-back request/address/data in, ack out
//   mem_enable     : memory transfer active (held until mem_ack)
//   mem_rw         : 1 = write, 0 = read
//   mem_addr       : memory address, constant while mem_enable is high
//   mem_data_out   : write line, constant while mem_enable is high
//   mem_ack        : memory completion pulse (only honoured while busy)
//   mem_data_in    : read line from memory, captured with mem_ack
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef WIDTH
`define WIDTH 128
`endif

module mem_arbiter #(
    parameter int ADDR_W = `REG_SIZE,
    parameter int LINE_W = `WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [LINE_W-1:0] dc_read_data,
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    output logic              mem_enable,
    output logic              mem_rw,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_data_in,
    output logic [LINE_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GR_NONE = 2'd0,
        GR_IC   = 2'd1,
        GR_DCR  = 2'd2,
        GR_DCW  = 2'd3
    } grant_t;

    state_t              r_state;
    grant_t              r_grant;
    logic                r_mem_enable;
    logic                r_mem_rw;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_data_out;
    logic                r_ic_ack;
    logic                r_dcr_ack;
    logic                r_dcw_ack;
    logic [LINE_W-1:0]   r_ic_data;
    logic [LINE_W-1:0]   r_dc_data;

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_grant        <= GR_NONE;
            r_mem_enable   <= 1'b0;
            r_mem_rw       <= 1'b0;
            r_mem_addr     <= {ADDR_W{1'b0}};
            r_mem_data_out <= {LINE_W{1'b0}};
            r_ic_ack       <= 1'b0;
            r_dcr_ack      <= 1'b0;
            r_dcw_ack      <= 1'b0;
            r_ic_data      <= {LINE_W{1'b0}};
            r_dc_data      <= {LINE_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ic_ack  <= 1'b0;
                    r_dcr_ack <= 1'b0;
                    r_dcw_ack <= 1'b0;
                    // Write-back first so an evicted dirty line lands in
                    // memory before the refill read of the same set.
                    if (dc_write_req) begin
                        r_grant        <= GR_DCW;
                        r_mem_addr     <= dc_write_addr;
                        r_mem_data_out <= dc_write_data;
                        r_mem_rw       <= 1'b1;
                        r_mem_enable   <= 1'b1;
                        r_state        <= ST_BUSY;
                    end else if (dc_read_req) begin
                        r_grant      <= GR_DCR;
                        r_mem_addr   <= dc_read_addr;
                        r_mem_rw     <= 1'b0;
                        r_mem_enable <= 1'b1;
                        r_state      <= ST_BUSY;
                    end else if (ic_read_req) begin
                        r_grant      <= GR_IC;
                        r_mem_addr   <= ic_read_addr;
                        r_mem_rw     <= 1'b0;
                        r_mem_enable <= 1'b1;
                        r_state      <= ST_BUSY;
                    end else begin
                        r_grant      <= GR_NONE;
                        r_mem_enable <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end

                ST_BUSY: begin
                    // Requests are not re-sampled here; address, rw and
                    // write data stay frozen until memory acknowledges.
                    if (mem_ack) begin
                        r_mem_enable <= 1'b0;
                        r_state      <= ST_ACK;
                        case (r_grant)
                            GR_IC: begin
                                r_ic_data <= mem_data_in;
                                r_ic_ack  <= 1'b1;
                            end
                            GR_DCR: begin
                                r_dc_data <= mem_data_in;
                                r_dcr_ack <= 1'b1;
                            end
                            GR_DCW: begin
                                r_dcw_ack <= 1'b1;
                            end
                            default: begin
                                r_ic_ack  <= 1'b0;
                                r_dcr_ack <= 1'b0;
                                r_dcw_ack <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_mem_enable <= 1'b1;
                        r_state      <= ST_BUSY;
                    end
                end

                ST_ACK: begin
                    r_ic_ack     <= 1'b0;
                    r_dcr_ack    <= 1'b0;
                    r_dcw_ack    <= 1'b0;
                    r_mem_enable <= 1'b0;
                    r_state      <= ST_GAP;
                end

                ST_GAP: begin
                    // Dead cycle: lets the served requester drop its level
                    // request before IDLE samples again.
                    r_grant      <= GR_NONE;
                    r_mem_enable <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_grant      <= GR_NONE;
                    r_mem_enable <= 1'b0;
                    r_ic_ack     <= 1'b0;
                    r_dcr_ack    <= 1'b0;
                    r_dcw_ack    <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign ic_read_ack  = r_ic_ack;
    assign ic_read_data = r_ic_data;
    assign dc_read_ack  = r_dcr_ack;
    assign dc_read_data = r_dc_data;
    assign dc_write_ack = r_dcw_ack;
    assign mem_enable   = r_mem_enable;
    assign mem_rw       = r_mem_rw;
    assign mem_addr     = r_mem_addr;
    assign mem_data_out = r_mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. The main process issues requests and pushes
// the expected memory transfers and requester acks into two queues. A
// memory responder answers mem_enable after a programmable latency. A
// monitor pops the queues whenever the DUT starts a transfer or pulses an ack.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int WHO_IC  = 0;
    localparam int WHO_DCR = 1;
    localparam int WHO_DCW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ic_read_req = 1'b0;
    logic [AW-1:0] ic_read_addr = '0;
    logic          ic_read_ack;
    logic [LW-1:0] ic_read_data;
    logic          dc_read_req = 1'b0;
    logic [AW-1:0] dc_read_addr = '0;
    logic          dc_read_ack;
    logic [LW-1:0] dc_read_data;
    logic          dc_write_req = 1'b0;
    logic [AW-1:0] dc_write_addr = '0;
    logic [LW-1:0] dc_write_data = '0;
    logic          dc_write_ack;
    logic          mem_enable;
    logic          mem_rw;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_data_in;
    logic [LW-1:0] mem_data_out;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .reset(reset),
        .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
        .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
        .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
        .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
        .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mem_exp_t;

    typedef struct {
        int            who;
        logic [LW-1:0] data;
    } ack_exp_t;

    mem_exp_t exp_mem[$];
    ack_exp_t exp_ack[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- memory responder ----------------
    logic          mem_auto = 1'b1;
    int            mem_lat = 0;
    logic [LW-1:0] mem_rdata = '0;
    logic          rnd_ack = 1'b0;
    int            spur_req = 0;

    initial begin
        int cnt;
        int done;
        cnt = 0;
        done = 0;
        mem_ack = 1'b0;
        mem_data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rnd_ack) begin
                mem_ack = 1'($urandom);
                mem_data_in = {4{$urandom}};
            end else if (spur_req != done) begin
                done = spur_req;
                mem_ack = 1'b1;
                mem_data_in = mem_rdata;
            end else if (mem_auto && mem_enable) begin
                if (cnt >= mem_lat) begin
                    mem_ack = 1'b1;
                    mem_data_in = mem_rdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic     mon_prev_en = 1'b0;
    logic     mon_prev_memack = 1'b0;
    logic     mon_prev_any_ack = 1'b0;
    int       mon_since_ack = 1000;
    mem_exp_t mon_cur;

    task automatic take_ack(input int who, input logic [LW-1:0] data);
        ack_exp_t a;
        if (exp_ack.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got ack from requester %0d, expected none", who);
        end else begin
            a = exp_ack.pop_front();
            check("ack_who", LW'(who), LW'(a.who));
            if (who != WHO_DCW) check("ack_data", data, a.data);
            check("ack_follows_mem_ack", LW'(mon_prev_memack), LW'(1));
        end
        mon_since_ack = 0;
    endtask

    initial begin
        logic any_ack;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_prev_en = 1'b0;
                mon_prev_memack = 1'b0;
                mon_prev_any_ack = 1'b0;
                mon_since_ack = 1000;
            end else begin
                mon_since_ack++;
                if (mem_enable && !mon_prev_en) begin
                    if (exp_mem.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_transfer: got rw %b addr %h, expected no transfer",
                                 mem_rw, mem_addr);
                        mon_cur.rw = mem_rw;
                        mon_cur.addr = mem_addr;
                        mon_cur.wdata = mem_data_out;
                    end else begin
                        mon_cur = exp_mem.pop_front();
                    end
                    check("gap_before_grant", LW'(mon_since_ack >= 3), LW'(1));
                end
                if (mem_enable) begin
                    check("mem_rw", LW'(mem_rw), LW'(mon_cur.rw));
                    check("mem_addr", LW'(mem_addr), LW'(mon_cur.addr));
                    if (mon_cur.rw) check("mem_data_out", mem_data_out, mon_cur.wdata);
                end
                any_ack = ic_read_ack | dc_read_ack | dc_write_ack;
                if (ic_read_ack)  take_ack(WHO_IC, ic_read_data);
                if (dc_read_ack)  take_ack(WHO_DCR, dc_read_data);
                if (dc_write_ack) take_ack(WHO_DCW, '0);
                if (any_ack && mon_prev_any_ack) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ack_pulse_width: got ack high 2 cycles, expected 1");
                end
                mon_prev_any_ack = any_ack;
                mon_prev_memack = mem_ack & mem_enable;
                mon_prev_en = mem_enable;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input int who, input int max_cyc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            case (who)
                WHO_IC:  got = ic_read_ack;
                WHO_DCR: got = dc_read_ack;
                default: got = dc_write_ack;
            endcase
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack from requester %0d within %0d cycles", who, max_cyc);
        end
    endtask

    task automatic wait_enable(input int max_cyc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            got = mem_enable;
        end
        check("enable_within_bound", LW'(got), LW'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_enable"},   LW'(mem_enable),   LW'(0));
        check({tag, "_mem_rw"},       LW'(mem_rw),       LW'(0));
        check({tag, "_ic_ack"},       LW'(ic_read_ack),  LW'(0));
        check({tag, "_dcr_ack"},      LW'(dc_read_ack),  LW'(0));
        check({tag, "_dcw_ack"},      LW'(dc_write_ack), LW'(0));
        check({tag, "_mem_addr"},     LW'(mem_addr),     LW'(0));
        check({tag, "_mem_data_out"}, mem_data_out,      LW'(0));
        check({tag, "_ic_data"},      ic_read_data,      LW'(0));
        check({tag, "_dc_data"},      dc_read_data,      LW'(0));
    endtask

    // ---------------- main stimulus ----------------
    logic [LW-1:0] exp_ic_data = '0;
    logic [LW-1:0] exp_dc_data = '0;

    initial begin
        logic [LW-1:0] rd1;
        logic [LW-1:0] rd2;
        logic [LW-1:0] wd;

        // Reset with random inputs toggling.
        rnd_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ic_read_req   = 1'($urandom);
            dc_read_req   = 1'($urandom);
            dc_write_req  = 1'($urandom);
            ic_read_addr  = $urandom;
            dc_read_addr  = $urandom;
            dc_write_addr = $urandom;
            dc_write_data = {4{$urandom}};
        end
        check_reset_outputs("reset");
        ic_read_req = 1'b0;
        dc_read_req = 1'b0;
        dc_write_req = 1'b0;
        rnd_ack = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_no_enable", LW'(mem_enable), LW'(0));
        end

        // Icache read, memory acks after 3 wait cycles.
        mem_lat = 3;
        rd1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        mem_rdata = rd1;
        exp_mem.push_back('{1'b0, 32'h0000_1000, '0});
        exp_ack.push_back('{WHO_IC, rd1});
        exp_ic_data = rd1;
        @(negedge clk);
        ic_read_addr = 32'h0000_1000;
        ic_read_req = 1'b1;
        wait_ack(WHO_IC, 20);
        ic_read_req = 1'b0;
        check("ic_data_held", ic_read_data, exp_ic_data);
        repeat (4) @(negedge clk);

        // Priority: all three requests rise together.
        mem_lat = 1;
        wd  = 128'h11112222_33334444_55556666_77778888;
        rd1 = 128'hA5A5A5A5_00000080_0F0F0F0F_12345678;
        rd2 = 128'h5A5A5A5A_00000100_F0F0F0F0_87654321;
        exp_mem.push_back('{1'b1, 32'h0000_0040, wd});
        exp_mem.push_back('{1'b0, 32'h0000_0080, '0});
        exp_mem.push_back('{1'b0, 32'h0000_0100, '0});
        exp_ack.push_back('{WHO_DCW, '0});
        exp_ack.push_back('{WHO_DCR, rd1});
        exp_ack.push_back('{WHO_IC, rd2});
        exp_dc_data = rd1;
        exp_ic_data = rd2;
        dc_write_addr = 32'h0000_0040;
        dc_write_data = wd;
        dc_read_addr  = 32'h0000_0080;
        ic_read_addr  = 32'h0000_0100;
        dc_write_req = 1'b1;
        dc_read_req  = 1'b1;
        ic_read_req  = 1'b1;
        wait_ack(WHO_DCW, 20);
        dc_write_req = 1'b0;
        mem_rdata = rd1;
        wait_ack(WHO_DCR, 20);
        dc_read_req = 1'b0;
        mem_rdata = rd2;
        wait_ack(WHO_IC, 20);
        ic_read_req = 1'b0;
        check("prio_dc_data", dc_read_data, exp_dc_data);
        check("prio_ic_data", ic_read_data, exp_ic_data);
        repeat (4) @(negedge clk);

        // Back-to-back: request still high in the cycle after its ack.
        mem_lat = 0;
        rd1 = 128'h0BADC0DE_0BADC0DE_0BADC0DE_00000200;
        mem_rdata = rd1;
        exp_mem.push_back('{1'b0, 32'h0000_0200, '0});
        exp_ack.push_back('{WHO_DCR, rd1});
        exp_dc_data = rd1;
        dc_read_addr = 32'h0000_0200;
        dc_read_req = 1'b1;
        wait_ack(WHO_DCR, 20);
        @(posedge clk);
        @(posedge clk);
        #1 dc_read_req = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_single_transfer", LW'(exp_mem.size()), LW'(0));

        // Spurious mem_ack while idle.
        mem_rdata = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
        spur_req++;
        repeat (4) @(negedge clk);
        check("spur_ic_data", ic_read_data, exp_ic_data);
        check("spur_dc_data", dc_read_data, exp_dc_data);
        check("spur_no_enable", LW'(mem_enable), LW'(0));

        // Reset in the middle of a transfer, then a late mem_ack.
        mem_auto = 1'b0;
        exp_mem.push_back('{1'b0, 32'h0000_0300, '0});
        dc_read_addr = 32'h0000_0300;
        dc_read_req = 1'b1;
        wait_enable(10);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        dc_read_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #2 reset = 1'b1;
        mem_rdata = 128'h12121212_34343434_56565656_78787878;
        @(posedge clk);
        spur_req++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("late_ack_no_enable", LW'(mem_enable), LW'(0));
            check("late_ack_no_dcr_ack", LW'(dc_read_ack), LW'(0));
        end
        check("late_ack_dc_data", dc_read_data, LW'(0));
        mem_auto = 1'b1;

        repeat (3) @(negedge clk);
        check("mem_queue_empty", LW'(exp_mem.size()), LW'(0));
        check("ack_queue_empty", LW'(exp_ack.size()), LW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port main-memory arbiter between the instruction cache, the data cache and the external memory interface of `cpu`. Accepts the Icache line-fill read, the Dcache line-fill read and the Dcache write-back, and grants one at a time by fixed priority. Runs each granted transfer to completion on the memory enable/ack handshake, then returns the ack and line data to the winning cache.

## Interface
- `ADDR_W`, default `` `REG_SIZE ``: byte address width.
- `LINE_W`, default `` `WIDTH ``: cache line / memory data width.

Ports, listed as name, direction, width, meaning:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `ic_read_req` in 1: Icache line-read request (level).
- `ic_read_addr` in ADDR_W: Icache line address.
- `ic_read_ack` out 1: one-cycle completion pulse to Icache.
- `ic_read_data` out LINE_W: line returned to Icache.
- `dc_read_req` in 1: Dcache line-read request (level).
- `dc_read_addr` in ADDR_W: Dcache read address.
- `dc_read_ack` out 1: one-cycle completion pulse to Dcache read.
- `dc_read_data` out LINE_W: line returned to Dcache.
- `dc_write_req` in 1: Dcache write-back request (level).
- `dc_write_addr` in ADDR_W: write-back address.
- `dc_write_data` in LINE_W: write-back line.
- `dc_write_ack` out 1: one-cycle completion pulse to Dcache write.
- `mem_enable` out 1: memory transfer active.
- `mem_rw` out 1: 1 = write, 0 = read.
- `mem_ack` in 1: memory completion pulse.
- `mem_addr` out ADDR_W: memory address.
- `mem_data_in` in LINE_W: read data from memory.
- `mem_data_out` out LINE_W: write data to memory.

## Operation
- FSM states: IDLE, BUSY, ACK, GAP.
- IDLE: sample requests. Priority is `dc_write_req` > `dc_read_req` > `ic_read_req`.
  - Write-back wins first so an evicted dirty line reaches memory before the refill read.
  - On any request, latch the grant ID, address, write data and `mem_rw` into output registers, then go to BUSY.
- BUSY:
  - `mem_enable`=1, with `mem_addr`, `mem_rw` and `mem_data_out` held constant.
  - Requester inputs are not re-sampled.
  - On `mem_ack`=1: for a read, capture `mem_data_in` into the granted requester's data register. Then go to ACK.
- ACK: `mem_enable`=0. The granted requester's ack is 1 for exactly this cycle. Next state is GAP.
- GAP: one cycle with no grant. This gives a requester time to drop its request after seeing ack, so no request is granted twice. Next state is IDLE.
- `ic_read_data` and `dc_read_data` hold their last captured line until the next read to that same requester completes.
- `mem_ack` in IDLE, ACK or GAP is ignored.
- Starvation: fixed priority, no aging. Icache waits while Dcache requests persist; this is accepted, because Dcache requests are bounded per miss.
- Reset (any state, including mid-transfer):
  - State returns to IDLE, the transfer in flight is abandoned, and no ack is issued for it.
  - A late `mem_ack` after reset is ignored.
  - All outputs are cleared: `mem_enable`, `mem_rw`, all acks = 0; `mem_addr`, `mem_data_out`, `ic_read_data`, `dc_read_data` = 0.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Request high at edge N (state IDLE) → `mem_enable`=1 from edge N+1.
- Memory returns `mem_ack` sampled at edge M:
  - `mem_enable` falls at M+1.
  - Ack and read data are valid during cycle M+1 to M+2.
  - GAP occupies M+2 to M+3.
  - The earliest next grant is sampled at edge M+3.
- Minimum transfer with a zero-wait memory (ack in the first enable cycle) is 4 cycles, request to next IDLE.
- Simultaneous requests in one IDLE cycle: the highest priority wins. Losers are served in later IDLE windows, in priority order.
- A request deasserted before it is granted is dropped silently.

## Test plan
- Reset values:
  - Stimulus: assert `reset`=0 with random inputs.
  - Required: every output is 0.
  - Then release reset, hold all requests low for 10 cycles: `mem_enable` stays 0.
- Icache read:
  - Stimulus: `ic_read_req`=1, addr 0x0000_1000; memory acks 3 cycles after enable with data 0xDEADBEEF….
  - Required: `mem_rw`=0, `mem_addr`=0x1000, `ic_read_ack` is a single pulse, `ic_read_data` = that data, `dc_read_ack`=0.
- Priority:
  - Stimulus: all three requests rise in the same cycle; write addr 0x40, read addr 0x80, ic addr 0x100.
  - Required: memory sees, in order, write 0x40, then read 0x80, then read 0x100, with one matching ack each and GAP between transfers.
- Back-to-back:
  - Stimulus: `dc_read_req` held high through its ack, dropped on the cycle after the ack.
  - Required: exactly one memory transfer and one `dc_read_ack`.
- Reset mid-transfer:
  - Stimulus: assert reset while BUSY, then pulse `mem_ack` one cycle after reset is released.
  - Required: no requester ack, `mem_enable`=0, FSM stays IDLE.
- Spurious ack:
  - Stimulus: `mem_ack` pulses in IDLE.
  - Required: no ack outputs change and read data registers are unchanged.
